// File: rtl/uart_rx_pkg.sv
// Shared types and default parameters for the UART receive controller.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module rx_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the raw line and resolve metastability over two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: start detection, mid-bit sampling, stop/break handling.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 baud_tick,
  input  logic                                 rx_in,
  output logic                                 sel,
  output logic                                 shift_en,
  output logic                                 shift_in,
  output logic                                 rx_done,
  output logic                                 frame_err,
  output logic                                 busy,
  output logic [$clog2(OVERSAMPLE)-1:0]        tick_cnt,
  output logic [$clog2(DATA_BITS+1)-1:0]       bit_cnt
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          shift_en_q, shift_en_d;
  logic          shift_in_q, shift_in_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;

  rx_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  // State, counters and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_en_q  <= 1'b0;
      shift_in_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_en_q  <= shift_en_d;
      shift_in_q  <= shift_in_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; everything holds unless a baud tick arrives.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_en_d  = 1'b0;
    shift_in_d  = shift_in_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (baud_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end

        ST_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            shift_en_d = 1'b1;
            shift_in_d = rx_s;
            bit_d      = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              rx_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign sel       = (state_q == ST_DATA);
  assign busy      = (state_q != ST_IDLE);
  assign shift_en  = shift_en_q;
  assign shift_in  = shift_in_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign tick_cnt  = tick_q;
  assign bit_cnt   = bit_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: frame table, corner sequences, random frames.
module tb_uart_rx_controller;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx_in;
  logic       sel;
  logic       shift_en;
  logic       shift_in;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
  logic [3:0] tick_cnt;
  logic [3:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  int done_cnt  = 0;
  int err_cnt   = 0;
  int shift_cnt = 0;
  int sel_ticks = 0;

  logic [7:0] acc = '0;
  int         nb  = 0;
  logic [7:0] got_q[$];
  int         gotn_q[$];
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;

  uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .sel       (sel),
    .shift_en  (shift_en),
    .shift_in  (shift_in),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy),
    .tick_cnt  (tick_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observer: rebuilds received words from shift pulses, LSB first.
  always @(negedge clk) begin
    if (reset) begin
      nb  = 0;
      acc = '0;
    end else begin
      if (shift_en) begin
        acc = {shift_in, acc[7:1]};
        nb++;
        shift_cnt++;
      end
      if (baud_tick && sel) sel_ticks++;
      if (rx_done || frame_err) begin
        check("pulse_exclusive", int'(rx_done && frame_err), 0);
        check("pulse_width", int'((rx_done && prev_done) || (frame_err && prev_err)), 0);
      end
      if (rx_done) begin
        done_cnt++;
        got_q.push_back(acc);
        gotn_q.push_back(nb);
        nb = 0;
      end
      if (frame_err) begin
        err_cnt++;
        nb = 0;
      end
    end
    prev_done = rx_done;
    prev_err  = frame_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_tick();
    repeat (TD - 1) begin
      @(posedge clk);
      #1;
    end
    baud_tick = 1'b1;
    @(posedge clk);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic line(input logic v, input int n);
    rx_in = v;
    repeat (n) do_tick();
  endtask

  // Freeze ticks mid-DATA; expected counters derived from the frame tick index.
  task automatic do_stall(input int idx);
    int exp_tc;
    int exp_bc;
    exp_tc = (idx - 9) % OS;
    exp_bc = (idx - 9) / OS;
    check("stall_tick_before", int'(tick_cnt), exp_tc);
    check("stall_bit_before", int'(bit_cnt), exp_bc);
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    check("stall_tick_after", int'(tick_cnt), exp_tc);
    check("stall_bit_after", int'(bit_cnt), exp_bc);
    check("stall_sel", int'(sel), 1);
  endtask

  // Start bit, DATA_BITS data bits LSB first, one stop bit; OS ticks each.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_at);
    logic bits [10];
    int   idx;
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[b + 1] = d[b];
    bits[9] = stop;
    idx = 0;
    for (int b = 0; b < 10; b++) begin
      rx_in = bits[b];
      for (int t = 0; t < int'(OS); t++) begin
        if (idx == stall_at) do_stall(idx);
        do_tick();
        idx++;
      end
    end
  endtask

  task automatic check_word(input string name, input logic [7:0] exp);
    logic [7:0] g;
    int         n;
    if (got_q.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      g = got_q.pop_front();
      n = gotn_q.pop_front();
      check({name, "_data"}, int'(g), int'(exp));
      check({name, "_nbits"}, n, int'(DB));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sel"}, int'(sel), 0);
    check({name, "_shift_en"}, int'(shift_en), 0);
    check({name, "_shift_in"}, int'(shift_in), 0);
    check({name, "_rx_done"}, int'(rx_done), 0);
    check({name, "_frame_err"}, int'(frame_err), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_tick_cnt"}, int'(tick_cnt), 0);
    check({name, "_bit_cnt"}, int'(bit_cnt), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_err;
    int         exp_shift;
    int         exp_sel;
  } vec_t;

  initial begin
    vec_t       vt [6];
    logic [7:0] sent_q[$];
    int         d0, e0, s0, l0;
    int         n_rand_done;
    int         n_rand_err;
    logic [7:0] rd;
    logic       rstop;

    vt[0] = '{8'hA5, 1'b1, 1, 0, 8, 128};
    vt[1] = '{8'h00, 1'b1, 1, 0, 8, 128};
    vt[2] = '{8'hFF, 1'b1, 1, 0, 8, 128};
    vt[3] = '{8'h3C, 1'b0, 0, 1, 8, 128};
    vt[4] = '{8'h81, 1'b1, 1, 0, 8, 128};
    vt[5] = '{8'h7E, 1'b0, 0, 1, 8, 128};

    reset     = 1'b1;
    baud_tick = 1'b0;
    rx_in     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    line(1'b1, 4);

    // Frame table.
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt; l0 = sel_ticks;
      send_frame(vt[i].data, vt[i].stop, -1);
      if (!vt[i].stop) begin
        line(1'b0, 20);
        check("tbl_break_busy", int'(busy), 1);
        check("tbl_break_sel", int'(sel), 0);
      end
      line(1'b1, 4);
      check("tbl_done", done_cnt - d0, vt[i].exp_done);
      check("tbl_err", err_cnt - e0, vt[i].exp_err);
      check("tbl_shift", shift_cnt - s0, vt[i].exp_shift);
      check("tbl_sel_ticks", sel_ticks - l0, vt[i].exp_sel);
      check("tbl_idle_busy", int'(busy), 0);
      if (vt[i].exp_done == 1) check_word("tbl_word", vt[i].data);
    end

    // Start glitch: short low pulse rejected at mid start bit.
    d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
    line(1'b0, 4);
    check("glitch_busy_start", int'(busy), 1);
    line(1'b1, 12);
    check("glitch_busy_after", int'(busy), 0);
    check("glitch_shift", shift_cnt - s0, 0);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_err", err_cnt - e0, 0);

    // Break: stop bit low, line held low; no new frame until line returns high.
    d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
    send_frame(8'h3C, 1'b0, -1);
    line(1'b0, 40);
    check("break_err", err_cnt - e0, 1);
    check("break_done", done_cnt - d0, 0);
    check("break_shift", shift_cnt - s0, 8);
    check("break_busy", int'(busy), 1);
    check("break_sel", int'(sel), 0);
    line(1'b1, 4);
    check("break_exit_busy", int'(busy), 0);

    // Reset mid-frame after three data bits of 0xFF.
    d0 = done_cnt; e0 = err_cnt;
    line(1'b0, 16);
    line(1'b1, 52);
    check("midrst_bits_before", int'(bit_cnt), 3);
    check("midrst_sel_before", int'(sel), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    reset = 1'b0;
    line(1'b1, 4);
    check("midrst_done", done_cnt - d0, 0);
    check("midrst_err", err_cnt - e0, 0);
    send_frame(8'h55, 1'b1, -1);
    line(1'b1, 4);
    check_word("after_rst", 8'h55);

    // Back-to-back frames with no idle gap.
    d0 = done_cnt; s0 = shift_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    line(1'b1, 4);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_shift", shift_cnt - s0, 16);
    check_word("b2b_first", 8'h00);
    check_word("b2b_second", 8'hFF);

    // Baud ticks frozen mid-DATA.
    send_frame(8'hC3, 1'b1, 70);
    line(1'b1, 4);
    check_word("stall", 8'hC3);

    // Random frames, occasional bad stop bit, random gaps.
    d0 = done_cnt; e0 = err_cnt;
    n_rand_done = 0;
    n_rand_err  = 0;
    for (int i = 0; i < 20; i++) begin
      rd    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rstop, -1);
      if (rstop) begin
        sent_q.push_back(rd);
        n_rand_done++;
      end else begin
        n_rand_err++;
        line(1'b0, $urandom_range(0, 10));
        line(1'b1, 1);
      end
      line(1'b1, $urandom_range(0, 6));
    end
    line(1'b1, 4);
    check("rand_done", done_cnt - d0, n_rand_done);
    check("rand_err", err_cnt - e0, n_rand_err);
    while (sent_q.size() > 0) begin
      rd = sent_q.pop_front();
      check_word("rand", rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
